fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL run on one clock, with an asynchronous, active-low reset.
REQ-002 Parameters SHALL be:
- DW, default 4, data width.
- DEPTH, default 4, FIFO depth.
- MAX_BURST, default 2, maximum back-to-back grants to one requester while the other is waiting.
- LW = clog2(DEPTH)+1, derived, width of level.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rstN  in  1  async active-low reset
- req0  in  1  producer 0 write request
- data0  in  DW  producer 0 write data
- gnt0  out  1  producer 0 data accepted this cycle
- req1  in  1  producer 1 write request
- data1  in  DW  producer 1 write data
- gnt1  out  1  producer 1 data accepted this cycle
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DW  FIFO write data
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  DW  FIFO read data, valid in the same cycle as fifo_rd_en
- cons_rdy  in  1  consumer ready
- out_vld  out  1  output register valid
- out_data  out  DW  output register data
- level  out  LW  FIFO occupancy count

Function
REQ-004 The read strobe SHALL be fifo_rd_en = !fifo_empty && (!out_vld || cons_rdy), and the block SHALL never read an empty FIFO.
REQ-005 On fifo_rd_en, out_data SHALL load fifo_rd_data and out_vld SHALL be set the next cycle; otherwise, if cons_rdy is high, out_vld SHALL clear.
REQ-006 A consumer transfer SHALL occur exactly when out_vld && cons_rdy; out_data SHALL hold stable while out_vld && !cons_rdy.
REQ-007 The write qualifier SHALL be can_write = !fifo_full || fifo_rd_en, so a write into a full FIFO is allowed only with a same-cycle read.
REQ-008 The FSM SHALL have states IDLE, OWN0 and OWN1, plus a burst counter burst_cnt that saturates at MAX_BURST and a last-granted bit last_gnt.
REQ-009 The winner w SHALL be computed combinationally each cycle:
- In state OWNx: if req_x is high and not (req_other && burst_cnt == MAX_BURST), w = x.
- Otherwise, if req_other is high, w = other.
- Otherwise, if req_x is high, w = x.
- Otherwise there is no winner.
REQ-010 In IDLE, a single requester SHALL win; if both request, the requester != last_gnt SHALL win.
REQ-011 The grant SHALL be gnt_w = can_write, with fifo_wr_en = gnt0 | gnt1 and fifo_wr_data = data_w; gnt0 and gnt1 SHALL never both be high.
REQ-012 On a grant:
- state SHALL become OWNw and last_gnt SHALL become w;
- burst_cnt SHALL become sat(burst_cnt+1) if the previous state was OWNw, else 1.
REQ-013 With no req0 and no req1, state SHALL become IDLE and burst_cnt SHALL become 0.
REQ-014 When a request is blocked by !can_write, state, burst_cnt and last_gnt SHALL hold, and the winner choice SHALL be unchanged next cycle.
REQ-015 A lone requester SHALL be granted every cycle that can_write is high, with no forced yield.
REQ-016 level SHALL update as follows:
- +1 on fifo_wr_en && !fifo_rd_en;
- -1 on fifo_rd_en && !fifo_wr_en;
- unchanged otherwise, including a simultaneous write and read.
REQ-017 level SHALL always stay within 0..DEPTH; an embedded assertion SHALL flag any write at level == DEPTH without a same-cycle read.

Reset
REQ-018 While rstN is low, the following SHALL clear asynchronously:
- state = IDLE, burst_cnt = 0, last_gnt = 1 (so req0 wins the first tie);
- level = 0, out_vld = 0, out_data = 0.
REQ-019 During reset, gnt0, gnt1, fifo_wr_en and fifo_rd_en SHALL be 0; reset asserted mid-burst SHALL abandon the burst with no grant in the reset cycle.

Verification
REQ-020 Reset check: assert rstN=0 mid-traffic -> in the same cycle all grants, strobes, out_vld and level read 0; after release, a tie grants req0 first.
REQ-021 Fairness check: req0=req1=1 continuously, cons_rdy=1, MAX_BURST=2 -> grant sequence 0,0,1,1,0,0,1,1.
REQ-022 Lone-requester check: req1=1 alone for 6 cycles with the FIFO never full -> gnt1=1 in all 6 cycles, state OWN1.
REQ-023 Fill check: cons_rdy=0, req0 with data 1..6 -> exactly 5 grants (1 held in the output register, 2..5 in the FIFO), then gnt0=0, level=4, out_data=1.
REQ-024 Full-with-read check: level=4, out_vld=1, cons_rdy=1, req0=1 -> gnt0 and fifo_rd_en both high in the same cycle, level stays 4, out_data advances to the next FIFO word.
REQ-025 Blocked-tie check: FIFO full, cons_rdy=0, state IDLE, req0=req1=1, last_gnt=0 -> no grant while blocked; when cons_rdy rises, gnt1 is the first grant.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter in front of an external FIFO, with a
// registered single-entry output stage and a FIFO occupancy counter.
module fifo_wr_arbiter #(
    parameter int DW        = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 2,
    parameter int LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_wr_data,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rd_data,
    input  logic          cons_rdy,
    output logic          out_vld,
    output logic [DW-1:0] out_data,
    output logic [LW-1:0] level
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          last_q, last_d;
    logic [LW-1:0] level_q, level_d;
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic own1, rx, ro;
    logic win_vld, win;
    logic can_write, gnt;
    state_e win_st;

    assign own1 = (state_q == OWN1);
    assign rx   = own1 ? req1 : req0;
    assign ro   = own1 ? req0 : req1;

    // The owner keeps the FIFO until it stops asking or has used its burst
    always_comb begin
        win_vld = 1'b0;
        win     = 1'b0;
        if (state_q == IDLE) begin
            if (req0 && req1) begin
                win_vld = 1'b1;
                win     = !last_q;
            end else if (req0 || req1) begin
                win_vld = 1'b1;
                win     = req1;
            end
        end else if (rx && !(ro && burst_q == BMAX)) begin
            win_vld = 1'b1;
            win     = own1;
        end else if (ro) begin
            win_vld = 1'b1;
            win     = !own1;
        end
    end

    assign fifo_rd_en   = rstN && !fifo_empty && (!out_vld_q || cons_rdy);
    assign can_write    = !fifo_full || fifo_rd_en;
    assign gnt          = rstN && win_vld && can_write;
    assign gnt0         = gnt && !win;
    assign gnt1         = gnt && win;
    assign fifo_wr_en   = gnt;
    assign fifo_wr_data = win ? data1 : data0;
    assign win_st       = win ? OWN1 : OWN0;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        if (gnt) begin
            state_d = win_st;
            last_d  = win;
            if (state_q == win_st)
                burst_d = (burst_q == BMAX) ? BMAX : burst_q + 1'b1;
            else
                burst_d = BW'(1);
        end else if (!req0 && !req1) begin
            state_d = IDLE;
            burst_d = '0;
        end
    end

    always_comb begin
        level_d    = level_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        case ({fifo_wr_en, fifo_rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (fifo_rd_en) begin
            out_vld_d  = 1'b1;
            out_data_d = fifo_rd_data;
        end else if (cons_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            last_q     <= 1'b1;
            level_q    <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            last_q     <= last_d;
            level_q    <= level_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign level    = level_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstN)
        !(fifo_wr_en && !fifo_rd_en && level_q == LW'(DEPTH)));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small show-ahead FIFO
// model standing in for the external FIFO.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rstN;
    logic       req0, req1, gnt0, gnt1;
    logic [3:0] data0, data1;
    logic       fifo_full, fifo_empty, fifo_wr_en, fifo_rd_en;
    logic [3:0] fifo_wr_data, fifo_rd_data;
    logic       cons_rdy, out_vld;
    logic [3:0] out_data;
    logic [2:0] level;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] mem [4];
    logic [1:0] head, tail;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter dut (
        .clk(clk), .rstN(rstN),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .cons_rdy(cons_rdy), .out_vld(out_vld),
        .out_data(out_data), .level(level)
    );

    assign fifo_full    = (cnt == 3'd4);
    assign fifo_empty   = (cnt == 3'd0);
    assign fifo_rd_data = mem[head];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (fifo_wr_en) begin
                mem[tail] <= fifo_wr_data;
                tail      <= tail + 1'b1;
            end
            if (fifo_rd_en)
                head <= head + 1'b1;
            if (fifo_wr_en && !fifo_rd_en)
                cnt <= cnt + 1'b1;
            else if (fifo_rd_en && !fifo_wr_en)
                cnt <= cnt - 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 4'h0; data1 = 4'h0;
        cons_rdy = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (level !== 3'd0 || out_vld !== 1'b0 || out_data !== 4'h0) begin
            n_err++;
            $display("FAIL reset_state: got lvl=%0d vld=%b data=%h want 0/0/0",
                     level, out_vld, out_data);
        end
        req0 = 1'b1; req1 = 1'b1;
        data0 = 4'h3; data1 = 4'hC;
        cons_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cons_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, fifo_wr_en, fifo_rd_en} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {gnt0, gnt1, fifo_wr_en, fifo_rd_en});
        end
        n_cmp++;
        if (out_vld !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL reset_regs: got vld=%b lvl=%0d want 0/0",
                     out_vld, level);
        end
        @(negedge clk);
        rstN = 1'b1;
        cons_rdy = 1'b1;
        #1;
        n_cmp++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_tie: got g0=%b g1=%b want 1/0",
                     gnt0, gnt1);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp1;
        exp1 = 8'b1100_1100;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        data0 = 4'h3; data1 = 4'hC;
        cons_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (gnt1 !== exp1[i] || gnt0 !== !exp1[i] ||
                fifo_wr_data !== (exp1[i] ? 4'hC : 4'h3)) begin
                n_err++;
                $display("FAIL fair_%0d: got g0=%b g1=%b wd=%h want g1=%b",
                         i, gnt0, gnt1, fifo_wr_data, exp1[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lone();
        do_reset();
        req1 = 1'b1; data1 = 4'h5;
        cons_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
                n_err++;
                $display("FAIL lone_%0d: got g0=%b g1=%b want 0/1",
                         i, gnt0, gnt1);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (dut.state_q !== 2'd2) begin
            n_err++;
            $display("FAIL lone_state: got %0d want 2", dut.state_q);
        end
        req1 = 1'b0;
    endtask

    task automatic test_fill();
        logic [3:0] nxt;
        do_reset();
        cons_rdy = 1'b0;
        req0 = 1'b1;
        nxt = 4'd1;
        for (int i = 0; i < 7; i++) begin
            data0 = nxt;
            #1;
            n_cmp++;
            if (gnt0 !== (i < 5)) begin
                n_err++;
                $display("FAIL fill_gnt_%0d: got %b want %b",
                         i, gnt0, (i < 5));
            end
            if (gnt0)
                nxt = nxt + 1'b1;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (level !== 3'd4 || out_data !== 4'h1 || out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL fill_end: got lvl=%0d data=%h vld=%b want 4/1/1",
                     level, out_data, out_vld);
        end
        n_cmp++;
        if (data0 !== 4'h6 || fifo_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL fill_block: got d0=%h wr=%b want 6/0",
                     data0, fifo_wr_en);
        end
    endtask

    task automatic test_full_read();
        cons_rdy = 1'b1;
        #1;
        n_cmp++;
        if (gnt0 !== 1'b1 || fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b1) begin
            n_err++;
            $display("FAIL full_rd_same: got g0=%b rd=%b wr=%b want 1/1/1",
                     gnt0, fifo_rd_en, fifo_wr_en);
        end
        @(negedge clk);
        req0 = 1'b0;
        cons_rdy = 1'b0;
        #1;
        n_cmp++;
        if (level !== 3'd4 || out_data !== 4'h2 || out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL full_rd_after: got lvl=%0d data=%h vld=%b want 4/2/1",
                     level, out_data, out_vld);
        end
    endtask

    task automatic test_blocked_tie();
        do_reset();
        req0 = 1'b1; data0 = 4'h9;
        for (int i = 0; i < 6; i++)
            @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; data1 = 4'hA;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || level !== 3'd4) begin
                n_err++;
                $display("FAIL blk_hold_%0d: got g0=%b g1=%b lvl=%0d want 0/0/4",
                         i, gnt0, gnt1, level);
            end
            @(negedge clk);
        end
        cons_rdy = 1'b1;
        #1;
        n_cmp++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || fifo_rd_en !== 1'b1 ||
            fifo_wr_data !== 4'hA) begin
            n_err++;
            $display("FAIL blk_release: got g0=%b g1=%b rd=%b wd=%h want 0/1/1/a",
                     gnt0, gnt1, fifo_rd_en, fifo_wr_data);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        rstN = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 4'h0; data1 = 4'h0;
        cons_rdy = 1'b0;
        test_reset();
        test_fairness();
        test_lone();
        test_fill();
        test_full_read();
        test_blocked_tie();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
